// File: rtl/interrupt_controller.sv
// Prioritised interrupt front-end: edge latch, mask, fixed-priority dispatch.
// Optional SERVICE watchdog enabled by defining IRQ_TIMEOUT_EN.
module interrupt_controller #(
    parameter int N_SRC        = 4,
    parameter int VEC_W        = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_req,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             core_stall,
    input  logic             rti_done,
    output logic             interrupt,
    output logic [VEC_W-1:0] irq_vector,
    output logic             irq_active,
    output logic [N_SRC-1:0] irq_pending,
    output logic             irq_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        SERVICE = 2'd2
    } stateT;

    localparam int CNT_W = 4;

    if (N_SRC < 2 || N_SRC > 8 || (1 << VEC_W) < N_SRC ||
        PULSE_CYCLES < 1 || PULSE_CYCLES > 15 || TIMEOUT < 1) begin : gBadParams
        $error("interrupt_controller: illegal parameter set");
    end

    stateT            state;
    stateT            stateNext;
    logic [N_SRC-1:0] reqPrev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] edges;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clearMask;
    logic [VEC_W-1:0] sel;
    logic [VEC_W-1:0] vector;
    logic [VEC_W-1:0] vectorNext;
    logic [CNT_W-1:0] pulseCnt;
    logic [CNT_W-1:0] pulseCntNext;
    logic             any;

`ifdef IRQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0]  wdCnt;
    logic [WD_W-1:0]  wdCntNext;
    logic             timeoutFlag;
    logic             timeoutFlagNext;
`endif

    assign edges    = irq_req & ~reqPrev;
    assign eligible = pending & irq_mask;
    assign any      = |eligible;

    // Fixed priority: the lowest-index eligible source wins.
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) sel = VEC_W'(i);
        end
    end

    // Next-state logic for dispatch, pulse timing and service wait.
    always_comb begin
        stateNext    = state;
        vectorNext   = vector;
        pulseCntNext = pulseCnt;
        clearMask    = '0;
`ifdef IRQ_TIMEOUT_EN
        wdCntNext       = wdCnt;
        timeoutFlagNext = timeoutFlag;
`endif
        unique case (state)
            IDLE: begin
                if (any && !core_stall) begin
                    stateNext    = FIRE;
                    vectorNext   = sel;
                    clearMask    = N_SRC'(1) << sel;
                    pulseCntNext = '0;
                end
            end
            FIRE: begin
                if (pulseCnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    stateNext = SERVICE;
`ifdef IRQ_TIMEOUT_EN
                    wdCntNext = '0;
`endif
                end else begin
                    pulseCntNext = pulseCnt + 1'b1;
                end
            end
            SERVICE: begin
                if (rti_done) begin
                    stateNext = IDLE;
                end
`ifdef IRQ_TIMEOUT_EN
                else if (wdCnt == WD_W'(TIMEOUT - 1)) begin
                    stateNext       = IDLE;
                    timeoutFlagNext = 1'b1;
                end else begin
                    wdCntNext = wdCnt + 1'b1;
                end
`endif
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, edge history and pending latch; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            reqPrev  <= '0;
            pending  <= '0;
            vector   <= '0;
            pulseCnt <= '0;
        end else begin
            state    <= stateNext;
            reqPrev  <= irq_req;
            pending  <= (pending & ~clearMask) | edges;
            vector   <= vectorNext;
            pulseCnt <= pulseCntNext;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdCnt       <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            wdCnt       <= wdCntNext;
            timeoutFlag <= timeoutFlagNext;
        end
    end

    assign irq_timeout = timeoutFlag;
`else
    assign irq_timeout = 1'b0;
`endif

    assign interrupt   = (state == FIRE);
    assign irq_active  = (state != IDLE);
    assign irq_vector  = vector;
    assign irq_pending = pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised and directed bench for interrupt_controller.
// Reference model tracks dispatch age per transaction, not FSM states.
module tb_interrupt_controller;

    localparam int N  = 4;
    localparam int VW = 2;
    localparam int P  = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_req;
    logic [N-1:0]  irq_mask;
    logic          core_stall;
    logic          rti_done;
    logic          interrupt;
    logic [VW-1:0] irq_vector;
    logic          irq_active;
    logic [N-1:0]  irq_pending;
    logic          irq_timeout;
    logic [8:0]    obs;

    int checks   = 0;
    int failures = 0;

    bit mPend[N];
    bit mPrev[N];
    bit mBusy;
    int mAge;
    int mVec;
    bit mTo;

    interrupt_controller #(
        .N_SRC(N), .VEC_W(VW), .PULSE_CYCLES(P), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .irq_req(irq_req),
        .irq_mask(irq_mask), .core_stall(core_stall),
        .rti_done(rti_done), .interrupt(interrupt),
        .irq_vector(irq_vector), .irq_active(irq_active),
        .irq_pending(irq_pending), .irq_timeout(irq_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {interrupt, irq_active, irq_timeout, irq_vector, irq_pending};

    // Expected outputs: interrupt is high during the first P cycles of a dispatch.
    function automatic logic [8:0] modelOut();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = mPend[i];
        return {mBusy && (mAge < P), mBusy, mTo, VW'(mVec), p};
    endfunction

    function automatic bit modelEligible();
        bit e = 0;
        for (int i = 0; i < N; i++) if (mPend[i] && irq_mask[i]) e = 1;
        return e;
    endfunction

    // One clock of the reference behaviour, using the inputs seen at the edge.
    function automatic void modelStep();
        bit newEdge[N];
        int pick;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mPend[i] = 0;
                mPrev[i] = 0;
            end
            mBusy = 0; mAge = 0; mVec = 0; mTo = 0;
            return;
        end
        for (int i = 0; i < N; i++) newEdge[i] = irq_req[i] && !mPrev[i];
        if (!mBusy) begin
            pick = -1;
            for (int i = N - 1; i >= 0; i--) if (mPend[i] && irq_mask[i]) pick = i;
            if (pick >= 0 && !core_stall) begin
                mBusy = 1; mAge = 0; mVec = pick; mPend[pick] = 0;
            end
        end else begin
            if (mAge >= P && rti_done) mBusy = 0;
`ifdef IRQ_TIMEOUT_EN
            else if (mAge - P == TO - 1) begin
                mBusy = 0; mTo = 1;
            end
`endif
            if (mBusy) mAge++;
        end
        for (int i = 0; i < N; i++) begin
            if (newEdge[i]) mPend[i] = 1;
            mPrev[i] = irq_req[i];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic drain();
        core_stall = 0;
        irq_req = '0;
        for (int k = 0; k < 60; k++) begin
            if (!mBusy && !modelEligible()) break;
            rti_done = mBusy && (mAge >= P);
            tick();
        end
        rti_done = 0;
    endtask

    task automatic test_reset();
        reset = 1; irq_req = '0; irq_mask = '0; core_stall = 0; rti_done = 0;
        tick(); tick();
        reset = 0;
        checks++;
        if (obs !== 9'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs, 9'b0);
        end
        checks++;
        if (obs !== modelOut()) begin
            failures++;
            $display("FAIL reset_model got=%b exp=%b", obs, modelOut());
        end
    endtask

    task automatic test_single();
        int hi = 0;
        int first = -1;
        irq_mask = 4'b1111;
        irq_req = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            tick();
            irq_req = '0;
            checks++;
            if (obs !== modelOut()) begin
                failures++;
                $display("FAIL single_c%0d got=%b exp=%b", c, obs, modelOut());
            end
            if (interrupt) begin
                hi++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (first !== 2 || hi !== P) begin
            failures++;
            $display("FAIL single_pulse got=first%0d/len%0d exp=first2/len%0d", first, hi, P);
        end
        checks++;
        if (irq_active !== 1'b1 || irq_vector !== 2'd2) begin
            failures++;
            $display("FAIL single_service got=%b/%0d exp=1/2", irq_active, irq_vector);
        end
        rti_done = 1;
        tick();
        rti_done = 0;
        checks++;
        if (irq_active !== 1'b0) begin
            failures++;
            $display("FAIL single_rti got=%b exp=0", irq_active);
        end
    endtask

    task automatic test_priority();
        irq_req = 4'b1010;
        for (int c = 1; c <= 6; c++) begin
            rti_done = (c == 5);
            tick();
            irq_req = '0;
            rti_done = 0;
            checks++;
            if (obs !== modelOut()) begin
                failures++;
                $display("FAIL prio_c%0d got=%b exp=%b", c, obs, modelOut());
            end
            if (c == 2) begin
                checks++;
                if (interrupt !== 1'b1 || irq_vector !== 2'd1) begin
                    failures++;
                    $display("FAIL prio_first got=%b/%0d exp=1/1", interrupt, irq_vector);
                end
            end
            if (c == 5) begin
                checks++;
                if (irq_active !== 1'b0 || irq_pending !== 4'b1000) begin
                    failures++;
                    $display("FAIL prio_idle got=%b/%b exp=0/1000", irq_active, irq_pending);
                end
            end
            if (c == 6) begin
                checks++;
                if (interrupt !== 1'b1 || irq_vector !== 2'd3) begin
                    failures++;
                    $display("FAIL prio_second got=%b/%0d exp=1/3", interrupt, irq_vector);
                end
            end
        end
        drain();
    endtask

    task automatic test_stall();
        core_stall = 1;
        irq_req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            core_stall = (c <= 5);
            tick();
            irq_req = '0;
            checks++;
            if (obs !== modelOut()) begin
                failures++;
                $display("FAIL stall_c%0d got=%b exp=%b", c, obs, modelOut());
            end
            if (c <= 5 && interrupt !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold got=%b exp=0", interrupt);
            end
        end
        checks++;
        if (interrupt !== 1'b1 || irq_vector !== 2'd0) begin
            failures++;
            $display("FAIL stall_release got=%b/%0d exp=1/0", interrupt, irq_vector);
        end
        core_stall = 0;
        drain();
    endtask

    task automatic test_mask();
        irq_mask = 4'b0000;
        irq_req = 4'b0010;
        tick();
        irq_req = '0;
        tick(); tick();
        checks++;
        if (irq_pending !== 4'b0010 || irq_active !== 1'b0) begin
            failures++;
            $display("FAIL mask_hold got=%b/%b exp=0010/0", irq_pending, irq_active);
        end
        irq_mask = 4'b0010;
        tick();
        checks++;
        if (interrupt !== 1'b1 || irq_vector !== 2'd1 || obs !== modelOut()) begin
            failures++;
            $display("FAIL mask_enable got=%b exp=%b", obs, modelOut());
        end
        irq_mask = 4'b1111;
        drain();
    endtask

    task automatic test_service_edge();
        irq_req = 4'b0100;
        tick();
        irq_req = '0;
        tick(); tick(); tick();
        irq_req = 4'b0001;
        tick();
        irq_req = '0;
        checks++;
        if (irq_pending !== 4'b0001 || irq_vector !== 2'd2 || irq_active !== 1'b1) begin
            failures++;
            $display("FAIL svc_latch got=%b exp=%b", obs, modelOut());
        end
        rti_done = 1;
        tick();
        rti_done = 0;
        tick();
        checks++;
        if (interrupt !== 1'b1 || irq_vector !== 2'd0 || obs !== modelOut()) begin
            failures++;
            $display("FAIL svc_redispatch got=%b exp=%b", obs, modelOut());
        end
        irq_req = 4'b1000;
        tick();
        irq_req = '0;
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (obs !== 9'b0) begin
            failures++;
            $display("FAIL reset_midfire got=%b exp=%b", obs, 9'b0);
        end
    endtask

    task automatic test_timeout();
        int svc = 0;
        irq_req = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            tick();
            irq_req = '0;
            checks++;
            if (obs !== modelOut()) begin
                failures++;
                $display("FAIL tmo_c%0d got=%b exp=%b", c, obs, modelOut());
            end
            if (irq_active && !interrupt) svc++;
        end
`ifdef IRQ_TIMEOUT_EN
        checks++;
        if (svc !== TO || irq_timeout !== 1'b1 || irq_active !== 1'b0) begin
            failures++;
            $display("FAIL tmo_fire got=svc%0d/%b/%b exp=svc%0d/1/0", svc, irq_timeout, irq_active, TO);
        end
`else
        checks++;
        if (svc !== 37 || irq_active !== 1'b1 || irq_timeout !== 1'b0) begin
            failures++;
            $display("FAIL tmo_wait got=svc%0d/%b/%b exp=svc37/1/0", svc, irq_active, irq_timeout);
        end
`endif
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (obs !== 9'b0) begin
            failures++;
            $display("FAIL tmo_reset got=%b exp=%b", obs, 9'b0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) irq_req[i] = ~irq_req[i];
                irq_mask[i] = ($urandom_range(4) != 0);
            end
            core_stall = ($urandom_range(3) == 0);
            rti_done = ($urandom_range(4) == 0);
            reset = ($urandom_range(199) == 0);
            tick();
            checks++;
            if (obs !== modelOut()) begin
                failures++;
                $display("FAIL rand_c%0d got=%b exp=%b", c, obs, modelOut());
            end
        end
        reset = 0; rti_done = 0; core_stall = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_stall();
        test_mask();
        test_service_edge();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
